// File: rtl/morse_sequencer.sv
// Morse letter transmitter: plays an S-Z table letter or a custom MSB-first pattern,
// one element per tick, followed by a fixed gap, with start/busy/done, repeat and abort.
module morse_sequencer #(
   parameter int TICK_DIV  = 25_000_000,
   parameter int CNT_W     = 25,
   parameter int GAP_UNITS = 3,
   parameter int PATTERN_W = 16,
   parameter int LEN_W     = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2:0]           select,
   input  logic                 use_custom,
   input  logic [PATTERN_W-1:0] pattern_in,
   input  logic [LEN_W-1:0]     len_in,
   input  logic                 repeat_en,
   input  logic                 abort,
   output logic                 out,
   output logic                 busy,
   output logic                 done
);

   localparam int GAP_W = $clog2(GAP_UNITS + 1);
   localparam logic [CNT_W-1:0] TICK_RELOAD = CNT_W'(TICK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(GAP_UNITS);
   localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(PATTERN_W);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t               state, state_next;
   logic [PATTERN_W-1:0] shift_reg, shift_next, shifted;
   logic [PATTERN_W-1:0] latched_pattern, pattern_next;
   logic [LEN_W-1:0]     latched_len, len_next;
   logic [LEN_W-1:0]     elem_cnt, elem_next;
   logic [GAP_W-1:0]     gap_cnt, gap_next;
   logic [CNT_W-1:0]     tick_cnt, tick_next;
   logic                 out_next, done_next, tick, launch;
   logic [15:0]          table_bits;
   logic [3:0]           table_len;
   logic [PATTERN_W-1:0] table_pattern, launch_pattern;
   logic [LEN_W-1:0]     raw_len, launch_len;

   always_comb begin
      table_bits = 16'h0000;
      table_len  = 4'd0;
      case (select)
         3'd0: begin table_bits = 16'hA800; table_len = 4'd5;  end
         3'd1: begin table_bits = 16'hE000; table_len = 4'd3;  end
         3'd2: begin table_bits = 16'hAE00; table_len = 4'd7;  end
         3'd3: begin table_bits = 16'hAB80; table_len = 4'd9;  end
         3'd4: begin table_bits = 16'hBB80; table_len = 4'd9;  end
         3'd5: begin table_bits = 16'hEAE0; table_len = 4'd11; end
         3'd6: begin table_bits = 16'hEBB8; table_len = 4'd13; end
         3'd7: begin table_bits = 16'hEEA0; table_len = 4'd11; end
         default: ;
      endcase
   end

   // Keep the table letter MSB-aligned whatever the pattern width is.
   assign table_pattern = PATTERN_W'({table_bits, {PATTERN_W{1'b0}}} >> 16);
   assign raw_len       = use_custom ? len_in : LEN_W'(table_len);

   // A fresh start takes the inputs; a repeat replays what was latched.
   always_comb begin
      if (state == IDLE) begin
         launch_pattern = use_custom ? pattern_in : table_pattern;
         launch_len     = (raw_len > LEN_MAX) ? LEN_MAX : raw_len;
      end else begin
         launch_pattern = latched_pattern;
         launch_len     = latched_len;
      end
   end

   assign tick    = (tick_cnt == '0);
   assign shifted = shift_reg << 1;
   assign busy    = (state != IDLE);

   always_comb begin
      state_next   = state;
      shift_next   = shift_reg;
      elem_next    = elem_cnt;
      gap_next     = gap_cnt;
      tick_next    = tick ? TICK_RELOAD : tick_cnt - CNT_W'(1);
      pattern_next = latched_pattern;
      len_next     = latched_len;
      out_next     = 1'b0;
      done_next    = 1'b0;
      launch       = 1'b0;
      case (state)
         IDLE: begin
            tick_next = TICK_RELOAD;
            if (start) begin
               launch       = 1'b1;
               pattern_next = launch_pattern;
               len_next     = launch_len;
            end
         end
         SEND: begin
            out_next = shift_reg[PATTERN_W-1];
            if (tick) begin
               if (elem_cnt == LEN_W'(1)) begin
                  state_next = GAP;
                  gap_next   = GAP_LOAD;
                  out_next   = 1'b0;
               end else begin
                  shift_next = shifted;
                  elem_next  = elem_cnt - LEN_W'(1);
                  out_next   = shifted[PATTERN_W-1];
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (gap_cnt == GAP_W'(1)) begin
                  if (repeat_en) begin
                     launch = 1'b1;
                  end else begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end else begin
                  gap_next = gap_cnt - GAP_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
      // A zero-length letter is just its gap.
      if (launch) begin
         if (launch_len == '0) begin
            state_next = GAP;
            gap_next   = GAP_LOAD;
         end else begin
            state_next = SEND;
            shift_next = launch_pattern;
            elem_next  = launch_len;
            out_next   = launch_pattern[PATTERN_W-1];
         end
      end
      if (abort) begin
         state_next = IDLE;
         out_next   = 1'b0;
         done_next  = 1'b0;
         tick_next  = TICK_RELOAD;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         shift_reg       <= '0;
         latched_pattern <= '0;
         latched_len     <= '0;
         elem_cnt        <= '0;
         gap_cnt         <= '0;
         tick_cnt        <= '0;
         out             <= 1'b0;
         done            <= 1'b0;
      end else begin
         state           <= state_next;
         shift_reg       <= shift_next;
         latched_pattern <= pattern_next;
         latched_len     <= len_next;
         elem_cnt        <= elem_next;
         gap_cnt         <= gap_next;
         tick_cnt        <= tick_next;
         out             <= out_next;
         done            <= done_next;
      end
   end

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: three instances with different tick/gap settings, each
// checked cycle by cycle against a queue of expected {out,busy,done} values.
module tb_morse_sequencer;

   logic        clock = 1'b0;
   logic        reset, start_a, start_b, start_c, use_custom, repeat_en, abort;
   logic [2:0]  select;
   logic [15:0] pattern_in;
   logic [4:0]  len_in;
   logic        out_a, busy_a, done_a;
   logic        out_b, busy_b, done_b;
   logic        out_c, busy_c, done_c;

   int          total = 0;
   int          bad   = 0;
   logic [2:0]  exp_q[$];

   always #5 clock = ~clock;

   morse_sequencer #(.TICK_DIV(4), .CNT_W(4), .GAP_UNITS(3)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .select(select),
      .use_custom(use_custom), .pattern_in(pattern_in), .len_in(len_in),
      .repeat_en(repeat_en), .abort(abort), .out(out_a), .busy(busy_a), .done(done_a));

   morse_sequencer #(.TICK_DIV(1), .CNT_W(4), .GAP_UNITS(1)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .select(select),
      .use_custom(use_custom), .pattern_in(pattern_in), .len_in(len_in),
      .repeat_en(repeat_en), .abort(abort), .out(out_b), .busy(busy_b), .done(done_b));

   morse_sequencer #(.TICK_DIV(2), .CNT_W(4), .GAP_UNITS(3)) dut_c (
      .clock(clock), .reset(reset), .start(start_c), .select(select),
      .use_custom(use_custom), .pattern_in(pattern_in), .len_in(len_in),
      .repeat_en(repeat_en), .abort(abort), .out(out_c), .busy(busy_c), .done(done_c));

   // tail: 0 = repeating pass (no done), 1 = done cycle only, 2 = done then one idle cycle
   function automatic void push_pass(input logic [15:0] pat, input int len, input int t,
                                     input int g, input int tail);
      for (int i = 0; i < len; i++)
         for (int c = 0; c < t; c++)
            exp_q.push_back({pat[15-i], 1'b1, 1'b0});
      for (int c = 0; c < g * t; c++)
         exp_q.push_back(3'b010);
      if (tail >= 1) exp_q.push_back(3'b001);
      if (tail == 2) exp_q.push_back(3'b000);
   endfunction

   task automatic test_reset();
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      use_custom = 1'b0; repeat_en = 1'b0; abort = 1'b0;
      select = 3'd0; pattern_in = 16'h0000; len_in = 5'd0;
      repeat (3) @(negedge clock);
      total += 3;
      if ({out_a, busy_a, done_a} !== 3'b000) begin
         bad++; $display("[TB] FAIL reset_a: got %b expected 000", {out_a, busy_a, done_a});
      end
      if ({out_b, busy_b, done_b} !== 3'b000) begin
         bad++; $display("[TB] FAIL reset_b: got %b expected 000", {out_b, busy_b, done_b});
      end
      if ({out_c, busy_c, done_c} !== 3'b000) begin
         bad++; $display("[TB] FAIL reset_c: got %b expected 000", {out_c, busy_c, done_c});
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_letter_s();
      logic [2:0] expv;
      int n = 1;
      select = 3'd0; use_custom = 1'b0; start_a = 1'b1;
      push_pass(16'hA800, 5, 4, 3, 2);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         expv = exp_q.pop_front();
         total++;
         if ({out_a, busy_a, done_a} !== expv) begin
            bad++; $display("[TB] FAIL letter_s cycle %0d: got %b expected %b", n, {out_a, busy_a, done_a}, expv);
         end
         start_a = 1'b0;
         n++;
      end
   endtask

   task automatic test_letter_z();
      logic [2:0] expv;
      int n = 1;
      select = 3'd7; use_custom = 1'b0; start_b = 1'b1;
      push_pass(16'hEEA0, 11, 1, 1, 2);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         expv = exp_q.pop_front();
         total++;
         if ({out_b, busy_b, done_b} !== expv) begin
            bad++; $display("[TB] FAIL letter_z cycle %0d: got %b expected %b", n, {out_b, busy_b, done_b}, expv);
         end
         start_b = 1'b0;
         n++;
      end
   endtask

   task automatic test_custom();
      logic [2:0] expv;
      int n = 1;
      use_custom = 1'b1; pattern_in = 16'hF000; len_in = 5'd4; start_c = 1'b1;
      push_pass(16'hF000, 4, 2, 3, 2);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         expv = exp_q.pop_front();
         total++;
         if ({out_c, busy_c, done_c} !== expv) begin
            bad++; $display("[TB] FAIL custom cycle %0d: got %b expected %b", n, {out_c, busy_c, done_c}, expv);
         end
         start_c = 1'b0;
         if (n == 3) begin
            start_c = 1'b1; pattern_in = 16'h00FF; use_custom = 1'b0; select = 3'd5;
         end
         n++;
      end
   endtask

   task automatic test_clamp();
      logic [2:0] expv;
      int n = 1;
      use_custom = 1'b1; pattern_in = 16'hFFFF; len_in = 5'd20; start_c = 1'b1;
      push_pass(16'hFFFF, 16, 2, 3, 2);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         expv = exp_q.pop_front();
         total++;
         if ({out_c, busy_c, done_c} !== expv) begin
            bad++; $display("[TB] FAIL clamp cycle %0d: got %b expected %b", n, {out_c, busy_c, done_c}, expv);
         end
         start_c = 1'b0;
         n++;
      end
   endtask

   task automatic test_repeat();
      logic [2:0] expv;
      int n = 1;
      select = 3'd1; use_custom = 1'b0; repeat_en = 1'b1; start_a = 1'b1;
      for (int p = 0; p < 3; p++) push_pass(16'hE000, 3, 4, 3, 0);
      push_pass(16'hE000, 3, 4, 3, 2);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         expv = exp_q.pop_front();
         total++;
         if ({out_a, busy_a, done_a} !== expv) begin
            bad++; $display("[TB] FAIL repeat cycle %0d: got %b expected %b", n, {out_a, busy_a, done_a}, expv);
         end
         start_a = 1'b0;
         if (n == 73) repeat_en = 1'b0;
         n++;
      end
   endtask

   task automatic test_abort();
      logic [2:0] expv;
      int n = 1;
      select = 3'd4; use_custom = 1'b0; start_c = 1'b1;
      push_pass(16'hBB80, 9, 2, 3, 2);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         expv = exp_q.pop_front();
         total++;
         if ({out_c, busy_c, done_c} !== expv) begin
            bad++; $display("[TB] FAIL abort cycle %0d: got %b expected %b", n, {out_c, busy_c, done_c}, expv);
         end
         start_c = 1'b0;
         if (n == 5) begin
            abort = 1'b1;
            exp_q.delete();
            exp_q.push_back(3'b000);
         end
         if (n == 6) begin
            abort = 1'b0;
            start_c = 1'b1;
            push_pass(16'hBB80, 9, 2, 3, 2);
         end
         n++;
      end
   endtask

   task automatic test_reset_mid_gap();
      logic [2:0] expv;
      int n = 1;
      select = 3'd0; use_custom = 1'b0; start_c = 1'b1;
      push_pass(16'hA800, 5, 2, 3, 2);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         expv = exp_q.pop_front();
         total++;
         if ({out_c, busy_c, done_c} !== expv) begin
            bad++; $display("[TB] FAIL reset_gap cycle %0d: got %b expected %b", n, {out_c, busy_c, done_c}, expv);
         end
         start_c = 1'b0;
         reset = 1'b0;
         if (n == 12) begin
            reset = 1'b1;
            #1;
            total++;
            if ({out_c, busy_c, done_c} !== 3'b010) begin
               bad++; $display("[TB] FAIL reset_before_edge: got %b expected 010", {out_c, busy_c, done_c});
            end
            exp_q.delete();
            exp_q.push_back(3'b000);
         end
         n++;
      end
      reset = 1'b0;
   endtask

   task automatic test_len_zero();
      logic [2:0] expv;
      int n = 1;
      use_custom = 1'b1; pattern_in = 16'hFFFF; len_in = 5'd0; start_c = 1'b1;
      push_pass(16'h0000, 0, 2, 3, 2);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         expv = exp_q.pop_front();
         total++;
         if ({out_c, busy_c, done_c} !== expv) begin
            bad++; $display("[TB] FAIL len_zero cycle %0d: got %b expected %b", n, {out_c, busy_c, done_c}, expv);
         end
         start_c = 1'b0;
         n++;
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] expv;
      int n = 1;
      select = 3'd1; use_custom = 1'b0; start_b = 1'b1;
      push_pass(16'hE000, 3, 1, 1, 1);
      push_pass(16'hE000, 3, 1, 1, 2);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         expv = exp_q.pop_front();
         total++;
         if ({out_b, busy_b, done_b} !== expv) begin
            bad++; $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", n, {out_b, busy_b, done_b}, expv);
         end
         start_b = (n == 5);
         n++;
      end
   endtask

   initial begin
      test_reset();
      test_letter_s();
      test_letter_z();
      test_custom();
      test_clamp();
      test_repeat();
      test_abort();
      test_reset_mid_gap();
      test_len_zero();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Parametrised Morse letter transmitter, successor to the fixed 16-bit shift-register encoder. It plays one letter from an internal S–Z table, or a caller-supplied custom pattern, onto a single output. Element duration comes from a parametrised tick divider, and each letter ends with a programmable inter-letter gap. It adds a start/busy/done handshake, repeat mode and abort, and sits between board switches/keys and an LED/buzzer pin.

## Interface
Parameters:
- `TICK_DIV`, default 25_000_000: clock cycles per Morse unit (0.5 s at 50 MHz); legal range ≥1.
- `CNT_W`, default 25: tick counter width; must satisfy 2^CNT_W ≥ TICK_DIV.
- `GAP_UNITS`, default 3: zero units appended after each letter; legal range ≥1.
- `PATTERN_W`, default 16: pattern register width; element order is MSB first.
- `LEN_W`, default 5: element-count width; must satisfy 2^LEN_W > PATTERN_W.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a transmission; sampled only in IDLE.
- `select` in 3: table letter (0=S … 7=Z); latched on start.
- `use_custom` in 1: 1 selects `pattern_in`/`len_in` instead of the table; latched on start.
- `pattern_in` in PATTERN_W: custom pattern, MSB-aligned.
- `len_in` in LEN_W: custom element count.
- `repeat` in 1: 1 replays the latched letter after its gap; sampled at gap end.
- `abort` in 1: synchronous cancel.
- `out` out 1: Morse output, registered.
- `busy` out 1: high from start acceptance until return to IDLE.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- Table entries (MSB-aligned pattern, length):
  - S 10101, 5
  - T 111, 3
  - U 1010111, 7
  - V 101010111, 9
  - W 101110111, 9
  - X 11101010111, 11
  - Y 1110101110111, 13
  - Z 11101110101, 11
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - `out`=0, `busy`=0.
  - `start`=1 latches the pattern and length into a shift register and element counter.
  - The tick counter is loaded with TICK_DIV-1.
  - Go to SEND.
- SEND:
  - `out` = shift register MSB.
  - On each tick: shift left (zero fill) and decrement the element counter.
  - When the last element's tick occurs, go to GAP with the gap counter set to GAP_UNITS.
- GAP:
  - `out`=0.
  - On each tick: decrement the gap counter.
  - On the final gap tick with `repeat`=1: reload the latched pattern and go to SEND. No `done` is generated.
  - On the final gap tick with `repeat`=0: go to IDLE and pulse `done`.
- Tick: the counter counts down to 0 and reloads TICK_DIV-1; tick = (count==0). With TICK_DIV=1, tick fires every cycle.
- Custom length 0: skip SEND and go straight to GAP (gap only). Custom length > PATTERN_W is clamped to PATTERN_W.
- `start` while busy: ignored. `select`, `use_custom` and `pattern_in` changes while busy: no effect.
- `abort`=1 (any state): next edge forces IDLE, `out`=0, `busy`=0, no `done`. Abort has priority over `start` in the same cycle.
- `reset`=1: same as abort, plus all counters and registers cleared. Reset has priority over everything.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0, state IDLE.
- Let T = TICK_DIV, G = GAP_UNITS, L = letter length, and let `start` be sampled at edge k.
- Element i (0-based) drives `out` during cycles k+1+i·T through k+(i+1)·T. Each element lasts exactly T cycles, with no glitch between adjacent equal bits.
- Gap: cycles k+1+L·T through k+(L+G)·T, with `out`=0.
- `busy` is 1 from cycle k+1 through k+(L+G)·T.
- Completion: in cycle k+(L+G)·T+1, `busy`=0 and `done`=1 for exactly one cycle.
- Repeat: the first element of the next pass starts at cycle k+(L+G)·T+1. `busy` stays 1 and the period is (L+G)·T.
- Back-to-back: a `start` present in the `done` cycle is accepted, so the next transmission begins one cycle later.
- Abort or reset at edge j: `out`=0 and `busy`=0 from cycle j+1.

## Test plan
- Reset, TICK_DIV=4, GAP_UNITS=3; `start` with select=0 (S) at edge 10:
  - `out` = 1,0,1,0,1 per 4-cycle unit over cycles 11–30, then 0 for cycles 31–42.
  - `done`=1 and `busy`=0 at cycle 43 only.
- select=7 (Z) with TICK_DIV=1, GAP_UNITS=1:
  - `out` = 11101110101 then 0 over 12 cycles.
  - `done` pulses in the 13th cycle after start.
- use_custom=1, pattern_in=16'hF000, len_in=4, TICK_DIV=2:
  - `out` high for 8 cycles, then low for 6 (GAP_UNITS=3), then `done`.
  - A second `start` pulse mid-transmission is ignored.
- Letter T with `repeat` held high:
  - Three consecutive passes, each with period (3+3)·T.
  - No `done` pulse until `repeat` is dropped; `done` then follows the end of the current pass.
- Abort during SEND element 2 of W:
  - `out`=0 and `busy`=0 at the next cycle, and `done` never pulses.
  - A `start` in the following cycle transmits W from its first element.
- Synchronous `reset` asserted mid-gap:
  - All outputs are 0 after the next edge, and the bench checks they are not cleared before it.
  - custom len_in=0 produces a gap-only transmission of G·T cycles followed by `done`.
